output_unit: RTL

- Per-output-port back end of the router; sits between one crossbar output and the outgoing link.
- Registers the switched flit onto the link.
- Keeps one downstream-buffer credit counter and one ownership state machine per VC.
- Consumes credits returned by the downstream input block and reports VC availability and credit status back to the allocators.

---
 rtl/noc_params.sv | 29 ++
 rtl/vc_credit_fsm.sv | 83 ++++++++
 rtl/output_unit.sv | 68 ++++++
 3 files changed

// File: rtl/noc_params.sv
// Router-wide parameters and types shared by the port back ends and the allocators.
package noc_params;

    localparam int VC_NUM      = 2;
    localparam int BUFFER_SIZE = 8;
    localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int FLIT_DATA_W = 16;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    // Per-VC ownership; the VC allocator reads the same encoding.
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } vc_state_t;

    typedef struct packed {
        flit_label_t             label;
        logic [VC_W-1:0]         vc_id;
        logic [FLIT_DATA_W-1:0]  data;
    } flit_t;

endpackage

// File: rtl/vc_credit_fsm.sv
// One VC of an output port: downstream credit counter plus packet ownership FSM.
module vc_credit_fsm
    import noc_params::*;
#(
    parameter int BUF_SIZE = BUFFER_SIZE,
    parameter int CNT_W    = $clog2(BUF_SIZE + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flit_hit,
    input  logic [1:0] flit_label,
    input  logic       credit_hit,
    output logic       credit_ok,
    output logic       free,
    output logic       err
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_SIZE);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    vc_state_t        r_state;
    vc_state_t        w_state_nxt;
    flit_label_t      w_label;
    logic             w_cnt_err;
    logic             w_proto_err;

    assign w_label = flit_label_t'(flit_label);

    // A flit and a credit on the same VC in one cycle cancel out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_cnt_err = 1'b0;
        if (flit_hit && !credit_hit) begin
            if (r_cnt == '0) w_cnt_err = 1'b1;
            else             w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (credit_hit && !flit_hit) begin
            if (r_cnt == FULL) w_cnt_err = 1'b1;
            else               w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_proto_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (flit_hit) begin
                    if (w_label == HEAD)          w_state_nxt = ACTIVE;
                    else if (w_label == HEADTAIL) w_state_nxt = DRAIN;
                    else                          w_proto_err = 1'b1;
                end
            end
            ACTIVE: begin
                if (flit_hit) begin
                    if (w_label == TAIL)          w_state_nxt = DRAIN;
                    else if (w_label != BODY)     w_proto_err = 1'b1;
                end
            end
            DRAIN: begin
                // Released only once every downstream slot has been returned.
                if (flit_hit)                     w_proto_err = 1'b1;
                else if (w_cnt_nxt == FULL)       w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= FULL;
            r_state <= IDLE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign credit_ok = (r_cnt != '0);
    assign free      = (r_state == IDLE);
    assign err       = w_cnt_err | w_proto_err;

endmodule

// File: rtl/output_unit.sv
// Output-port back end: registers the switched flit onto the link and tracks
// per-VC downstream credits and ownership for the allocators.
module output_unit
    import noc_params::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$bits(flit_t)-1:0] flit_i,
    input  logic                     valid_i,
    input  logic                     credit_valid_i,
    input  logic [VC_W-1:0]          credit_vc_i,
    output logic [$bits(flit_t)-1:0] flit_o,
    output logic                     valid_o,
    output logic [VC_NUM-1:0]        vc_free_o,
    output logic [VC_NUM-1:0]        vc_credit_o,
    output logic                     error_o
);

    localparam int CREDIT_W = $clog2(BUFFER_SIZE + 1);

    flit_t                     w_flit;
    logic [VC_NUM-1:0]         w_err;
    logic [$bits(flit_t)-1:0]  r_flit;
    logic                      r_valid;
    logic                      r_error;

    assign w_flit = flit_t'(flit_i);

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic w_flit_hit;
        logic w_credit_hit;

        assign w_flit_hit   = valid_i && (w_flit.vc_id == VC_W'(v));
        assign w_credit_hit = credit_valid_i && (credit_vc_i == VC_W'(v));

        vc_credit_fsm #(
            .BUF_SIZE (BUFFER_SIZE),
            .CNT_W    (CREDIT_W)
        ) u_vc (
            .clk        (clk),
            .rst        (rst),
            .flit_hit   (w_flit_hit),
            .flit_label (w_flit.label),
            .credit_hit (w_credit_hit),
            .credit_ok  (vc_credit_o[v]),
            .free       (vc_free_o[v]),
            .err        (w_err[v])
        );
    end

    // Link register: data only loads on a valid flit; error is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flit  <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) r_flit <= flit_i;
            if (|w_err)  r_error <= 1'b1;
        end
    end

    assign flit_o  = r_flit;
    assign valid_o = r_valid;
    assign error_o = r_error;

endmodule
